// File: rtl/i2c_apb_arbiter_if.sv
// Request/acknowledge and APB master bundle for i2c_apb_arbiter.
// master: arbiter side (drives APB controls, acks); slave: requesters plus APB target side.
interface i2c_apb_arbiter_if;
    logic [1:0] req_i;
    logic [6:0] req0_saddr_i;
    logic [6:0] req1_saddr_i;
    logic       req0_rw_i;
    logic       req1_rw_i;
    logic [7:0] req0_wdata_i;
    logic [7:0] req1_wdata_i;
    logic [1:0] ack_o;
    logic [7:0] rdata_o;
    logic       nack_o;
    logic       timeout_o;
    logic       busy_o;
    logic       psel_o;
    logic       penable_o;
    logic       pwrite_o;
    logic [7:0] paddr_o;
    logic [7:0] pwdata_o;
    logic [7:0] prdata_i;
    logic       pready_i;

    modport master (
        input  req_i, req0_saddr_i, req1_saddr_i,
        input  req0_rw_i, req1_rw_i, req0_wdata_i, req1_wdata_i,
        input  prdata_i, pready_i,
        output ack_o, rdata_o, nack_o, timeout_o, busy_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output req_i, req0_saddr_i, req1_saddr_i,
        output req0_rw_i, req1_rw_i, req0_wdata_i, req1_wdata_i,
        output prdata_i, pready_i,
        input  ack_o, rdata_o, nack_o, timeout_o, busy_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface

// File: rtl/i2c_apb_arbiter.sv
// Round-robin sequencer sharing an APB-programmed I2C master between two requesters.
// Ports: pclk_i, preset_i (async, active-high), bus (requests, acks/results, APB master).
module i2c_apb_arbiter #(
    parameter logic [7:0]  REG_SADDR  = 8'h00,
    parameter logic [7:0]  REG_TXDATA = 8'h01,
    parameter logic [7:0]  REG_CMD    = 8'h02,
    parameter logic [7:0]  REG_STATUS = 8'h03,
    parameter logic [7:0]  REG_RXDATA = 8'h04,
    parameter int unsigned POLL_MAX   = 16
) (
    input  logic               pclk_i,
    input  logic               preset_i,
    i2c_apb_arbiter_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE, SADDR, TXDATA, CMD, STAT, RXDATA, DONE
    } state_t;

    localparam logic [7:0] POLL_LIM = 8'(POLL_MAX);

    state_t     state;
    state_t     nxt;
    logic       gnt;
    logic       last_grant;
    logic [6:0] saddr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] poll_cnt;
    logic [7:0] poll_nxt;
    logic       pick;
    logic [6:0] sel_saddr;
    logic       sel_rw;
    logic [7:0] sel_wdata;
    logic [7:0] nxt_addr;
    logic [7:0] nxt_wdata;

    // Requester 1 wins a tie only when requester 0 was served last.
    assign pick      = bus.req_i[1] & (~bus.req_i[0] | ~last_grant);
    assign sel_saddr = pick ? bus.req1_saddr_i : bus.req0_saddr_i;
    assign sel_rw    = pick ? bus.req1_rw_i    : bus.req0_rw_i;
    assign sel_wdata = pick ? bus.req1_wdata_i : bus.req0_wdata_i;
    assign poll_nxt  = poll_cnt + 8'd1;

    // State following a completed transfer in the current state.
    always_comb begin
        nxt = DONE;
        unique case (state)
            SADDR:  nxt = rw ? CMD : TXDATA;
            TXDATA: nxt = CMD;
            CMD:    nxt = STAT;
            STAT: begin
                if (bus.prdata_i[0])
                    nxt = (bus.prdata_i[1] | ~rw) ? DONE : RXDATA;
                else if (poll_nxt == POLL_LIM)
                    nxt = DONE;
                else
                    nxt = STAT;
            end
            default: nxt = DONE;
        endcase
    end

    // Address/data for the SETUP phase of the next transfer.
    always_comb begin
        nxt_addr  = REG_STATUS;
        nxt_wdata = bus.pwdata_o;
        unique case (nxt)
            TXDATA: begin
                nxt_addr  = REG_TXDATA;
                nxt_wdata = wdata;
            end
            CMD: begin
                nxt_addr  = REG_CMD;
                nxt_wdata = {6'b0, rw, 1'b1};
            end
            RXDATA:  nxt_addr = REG_RXDATA;
            default: nxt_addr = REG_STATUS;
        endcase
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state         <= IDLE;
            gnt           <= 1'b0;
            last_grant    <= 1'b1;
            saddr         <= '0;
            rw            <= 1'b0;
            wdata         <= '0;
            poll_cnt      <= '0;
            bus.ack_o     <= '0;
            bus.rdata_o   <= '0;
            bus.nack_o    <= 1'b0;
            bus.timeout_o <= 1'b0;
            bus.busy_o    <= 1'b0;
            bus.psel_o    <= 1'b0;
            bus.penable_o <= 1'b0;
            bus.pwrite_o  <= 1'b0;
            bus.paddr_o   <= '0;
            bus.pwdata_o  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|bus.req_i) begin
                        gnt           <= pick;
                        saddr         <= sel_saddr;
                        rw            <= sel_rw;
                        wdata         <= sel_wdata;
                        bus.nack_o    <= 1'b0;
                        bus.timeout_o <= 1'b0;
                        bus.busy_o    <= 1'b1;
                        bus.psel_o    <= 1'b1;
                        bus.penable_o <= 1'b0;
                        bus.pwrite_o  <= 1'b1;
                        bus.paddr_o   <= REG_SADDR;
                        bus.pwdata_o  <= {1'b0, sel_saddr};
                        state         <= SADDR;
                    end
                end
                DONE: begin
                    bus.ack_o  <= '0;
                    bus.busy_o <= 1'b0;
                    last_grant <= gnt;
                    state      <= IDLE;
                end
                default: begin
                    if (!bus.penable_o) begin
                        bus.penable_o <= 1'b1;
                    end else if (bus.pready_i) begin
                        bus.penable_o <= 1'b0;
                        state         <= nxt;
                        if (nxt == DONE) begin
                            bus.psel_o   <= 1'b0;
                            bus.pwrite_o <= 1'b0;
                            bus.ack_o    <= gnt ? 2'b10 : 2'b01;
                        end else begin
                            bus.psel_o   <= 1'b1;
                            bus.pwrite_o <= (nxt == TXDATA) || (nxt == CMD);
                            bus.paddr_o  <= nxt_addr;
                            bus.pwdata_o <= nxt_wdata;
                        end
                        if (state == CMD)
                            poll_cnt <= '0;
                        if (state == STAT) begin
                            poll_cnt <= poll_nxt;
                            if (bus.prdata_i[0])
                                bus.nack_o <= bus.prdata_i[1];
                            else if (poll_nxt == POLL_LIM)
                                bus.timeout_o <= 1'b1;
                        end
                        if (state == RXDATA)
                            bus.rdata_o <= bus.prdata_i;
                    end
                end
            endcase
        end
    end

endmodule
